// File: rtl/heart_model_pkg.sv
// Shared constants, state encoding and io payload layouts for the heart model.
package heart_model_pkg;

    localparam int unsigned DEF_UNIT      = 1_000_000;
    localparam int unsigned DEF_PULSE_LEN = 4;
    localparam int unsigned DEF_REFRACT   = 200_000;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned RATE_W = 4;
    localparam int unsigned DROP_W = 3;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_BEAT    = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    typedef struct packed {
        logic [DROP_W-1:0] drop_n;
        logic [RATE_W-1:0] rate;
        logic              pace;
    } io_in_t;

endpackage

// File: rtl/heart_model_if.sv
// Pacemaker-side bundle of the heart model's packed io ports.
interface heart_model_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);
endinterface

// File: rtl/heart_interval_timer.sv
// Intrinsic interval timer: counts WAIT cycles, latches the rate at interval start, flags expiry.
module heart_interval_timer
    import heart_model_pkg::*;
#(
    parameter int unsigned UNIT = DEF_UNIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate,
    output logic              expire
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] interval;
    logic             asys;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            interval <= '0;
            asys     <= 1'b1;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            if (cnt == '0) begin
                asys     <= (rate == '0);
                interval <= (CNT_W'(rate) + CNT_W'(1)) * CNT_W'(UNIT);
            end
            if (enable) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Interval is at least 2 when not asystolic, so a fresh latch never collides with a compare.
    assign expire = !asys && (cnt == interval - CNT_W'(1));

endmodule

// File: rtl/heart_model.sv
// Behavioural heart: intrinsic beats at a programmable rate, pacing, refractory period and beat dropping.
module heart_model
    import heart_model_pkg::*;
#(
    parameter int unsigned UNIT      = DEF_UNIT,
    parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
    parameter int unsigned REFRACT   = DEF_REFRACT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] REFRACT_LAST = CNT_W'(REFRACT - 1);

    io_in_t            in_s;
    state_t            state, state_n;
    logic [CNT_W-1:0]  phase, phase_n;
    logic [DROP_W-1:0] drop_cnt, drop_cnt_n, adv;
    logic              cause, cause_n;
    logic              heartbeat, paced, missed, missed_n;
    logic              tmr_en, tmr_en_n, tmr_clear_c, expire, drop_c;

    assign in_s   = io_in_t'(io_in);
    assign adv    = drop_cnt + DROP_W'(1);
    assign drop_c = (in_s.drop_n != '0) && (adv >= in_s.drop_n);

    heart_interval_timer #(.UNIT(UNIT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear_c),
        .enable (tmr_en),
        .rate   (in_s.rate),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WAIT;
            phase     <= '0;
            drop_cnt  <= '0;
            cause     <= 1'b0;
            heartbeat <= 1'b0;
            paced     <= 1'b0;
            missed    <= 1'b0;
            tmr_en    <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            drop_cnt  <= drop_cnt_n;
            cause     <= cause_n;
            heartbeat <= (state_n == ST_BEAT);
            paced     <= (state_n == ST_BEAT) && cause_n;
            missed    <= missed_n;
            tmr_en    <= tmr_en_n;
        end
    end

    // Next state; pace wins over a same-cycle expiry, and a dropped expiry restarts the interval.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        drop_cnt_n  = drop_cnt;
        cause_n     = cause;
        missed_n    = 1'b0;
        tmr_clear_c = (state != ST_WAIT);
        unique case (state)
            ST_WAIT: begin
                if (in_s.pace) begin
                    state_n = ST_BEAT;
                    cause_n = 1'b1;
                    phase_n = '0;
                end else if (expire) begin
                    if (drop_c) begin
                        drop_cnt_n  = '0;
                        missed_n    = 1'b1;
                        tmr_clear_c = 1'b1;
                    end else begin
                        drop_cnt_n = adv;
                        state_n    = ST_BEAT;
                        cause_n    = 1'b0;
                        phase_n    = '0;
                    end
                end
            end
            ST_BEAT: begin
                if (phase == PULSE_LAST) begin
                    state_n = ST_REFRACT;
                    phase_n = '0;
                end else begin
                    phase_n = phase + CNT_W'(1);
                end
            end
            ST_REFRACT: begin
                if (phase == REFRACT_LAST) begin
                    state_n = ST_WAIT;
                    phase_n = '0;
                end else begin
                    phase_n = phase + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_WAIT;
                phase_n = '0;
            end
        endcase
        tmr_en_n = (state_n == ST_WAIT);
    end

    assign io_out = {3'b000, state, missed, paced, heartbeat};

endmodule
